// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions for the 5-stage RISC-V core:
// sequencing-controller state encodings, the default drain length,
// register-address width and the forwarding-mux select encodings.
package pipeline_ctrl_pkg;

    // Register-file address width (x0..x31)
    localparam int REG_ADDR_W = 5;

    // Sequencing controller states, kept as plain constants so older
    // tools and netlist viewers see stable 2-bit codes.
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t RUN    = 2'd0;
    localparam hz_state_t DRAIN  = 2'd1;
    localparam hz_state_t HALTED = 2'd2;

    // Unfrozen cycles needed for an accepted halt to retire from WB
    localparam int DRAIN_CYCLES_DEFAULT = 3;

    // Forwarding-mux select encodings shared with the forwarding unit
    localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB   = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // operand from EX/MEM result

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: purely combinational load-use comparator. Flags when
// the instruction in ID reads a register that the load currently in EX
// will write; x0 never creates a dependency. Kept separate so a second
// issue port can reuse it.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rd_nonzero;
    logic hit_rs1;
    logic hit_rs2;

    // Compare both ID sources against the EX load destination
    always_comb begin
        rd_nonzero = (ex_rd != '0);
        hit_rs1    = use_rs1 && (rs1 == ex_rd);
        hit_rs2    = use_rs2 && (rs2 == ex_rd);
        hazard     = ex_mem_read && rd_nonzero && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller. Each cycle decides whether
// the front end advances, stalls or flushes and whether the back end
// freezes; handles load-use stalls, EX redirects, data-memory wait states
// and the drain-to-halt after the halt ecall.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters as extra output ports.
module hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_is_halt,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        is_halted
);

    // Drain counter preload: counts DRAIN_CYCLES-1 down to 0
    localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

    hz_state_t  state_q;
    hz_state_t  state_d;
    logic [1:0] dcnt_q;
    logic [1:0] dcnt_d;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;

    load_use_detect u_load_use_detect (
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .use_rs1     (id_use_rs1),
        .use_rs2     (id_use_rs2),
        .ex_rd       (id_ex_rd),
        .ex_mem_read (id_ex_mem_read),
        .hazard      (load_use)
    );

    // Mealy output decode and next-state logic; everything is forced low
    // while reset is held so the core sees no enables during reset.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        if (reset_n) begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        // Memory wait wins over everything: EX holds, so a
                        // pending redirect is applied on the first free cycle.
                        pipe_freeze = 1'b1;
                        stall_evt   = 1'b1;
                    end else if (ex_redirect) begin
                        // Squash IF/ID and ID/EX; also kills a younger halt
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_evt    = 1'b1;
                    end else if (load_use) begin
                        id_ex_bubble = 1'b1;
                        stall_evt    = 1'b1;
                    end else if (id_is_halt) begin
                        if_id_flush = 1'b1;
                        state_d     = DRAIN;
                        dcnt_d      = DRAIN_INIT;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                DRAIN: begin
                    // Front end stays shut; older instructions retire.
                    // Redirects cannot occur from legal code here and are ignored.
                    if_id_flush = 1'b1;
                    if (mem_busy) begin
                        pipe_freeze = 1'b1;
                    end else if (dcnt_q == 2'd0) begin
                        state_d = HALTED;
                    end else begin
                        dcnt_d = dcnt_q - 2'd1;
                    end
                end
                HALTED: begin
                    pipe_freeze = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, drain counter and registered halt flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            dcnt_q    <= 2'd0;
            is_halted <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            is_halted <= (state_q == HALTED);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating increment so counters stick at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters for stall and redirect-flush cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (stall_evt) stall_cycles <= sat_inc(stall_cycles);
            if (flush_evt) flush_count  <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Output vector order in checks:
// {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, is_halted}.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_use_rs1, id_use_rs2, id_is_halt, id_ex_mem_read;
    logic        ex_redirect, mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, is_halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_is_halt     (id_is_halt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_redirect    (ex_redirect),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_freeze    (pipe_freeze),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
`endif
        .is_halted      (is_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, is_halted};
    endfunction

    function automatic logic [31:0] v6(input logic [5:0] v);
        return {26'd0, v};
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_halt = 1'b0;
        id_ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rs1();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #3;
        check("reset_outs", outs(), v6(6'b000000));
        tick(); tick();
        reset_n = 1'b1;
        #2;
        check("run_idle", outs(), v6(6'b110000));

        // Load-use on rs1: one bubble then normal flow
        tick(); load_use_rs1(); #2;
        check("lu_rs1_stall", outs(), v6(6'b000100));
        tick(); idle(); #2;
        check("lu_after", outs(), v6(6'b110000));

        // Load to x0 never stalls
        tick(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #2;
        check("lu_x0", outs(), v6(6'b110000));

        // rs2 dependency stalls only when rs2 is actually read
        tick(); idle(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; #2;
        check("lu_rs2_stall", outs(), v6(6'b000100));
        id_use_rs2 = 1'b0; #1;
        check("lu_rs2_unused", outs(), v6(6'b110000));
        id_use_rs2 = 1'b1; id_ex_mem_read = 1'b0; #1;
        check("lu_not_load", outs(), v6(6'b110000));

        // Redirect kills a younger halt
        tick(); idle(); ex_redirect = 1'b1; id_is_halt = 1'b1; #2;
        check("redir_halt", outs(), v6(6'b111100));
        tick(); idle(); #2;
        check("redir_no_drain", outs(), v6(6'b110000));

        // mem_busy 3 cycles with pending redirect: freeze only, then one flush
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); mem_busy = 1'b1; ex_redirect = 1'b1; #2;
            check("busy_redir_freeze", outs(), v6(6'b000010));
        end
        tick(); mem_busy = 1'b0; ex_redirect = 1'b1; #2;
        check("busy_redir_flush", outs(), v6(6'b111100));
        tick(); idle(); #2;
        check("busy_redir_after", outs(), v6(6'b110000));

        // Halt acceptance, drain with one frozen cycle, then halted
        tick(); id_is_halt = 1'b1; #2;
        check("halt_accept", outs(), v6(6'b001000));
        tick(); idle(); ex_redirect = 1'b1; #2;          // drain dcnt=2
        check("drain_1_redir_ignored", outs(), v6(6'b001000));
        tick(); idle(); mem_busy = 1'b1; #2;             // drain dcnt=1 frozen
        check("drain_2_frozen", outs(), v6(6'b001010));
        tick(); idle(); #2;                              // drain dcnt=1
        check("drain_3", outs(), v6(6'b001000));
        tick(); #2;                                      // drain dcnt=0
        check("drain_4", outs(), v6(6'b001000));
        tick(); #2;                                      // HALTED, flag not yet registered
        check("halted_pre_flag", outs(), v6(6'b000010));
        tick(); #2;                                      // 5th edge after acceptance
        check("halted_flag", outs(), v6(6'b000011));
        tick(); mem_busy = 1'b1; ex_redirect = 1'b1; id_is_halt = 1'b1; #2;
        check("halted_sticky", outs(), v6(6'b000011));

        // Asynchronous reset from HALTED
        reset_n = 1'b0; #1;
        check("reset_in_halted", outs(), v6(6'b000000));
        idle();
        tick();
        reset_n = 1'b1; #2;
        tick(); #2;
        check("run_after_reset", outs(), v6(6'b110000));

        // Reset in the middle of a drain returns to RUN for good
        tick(); id_is_halt = 1'b1; #2;
        check("halt_accept_2", outs(), v6(6'b001000));
        tick(); idle(); #2;
        check("drain_again", outs(), v6(6'b001000));
        reset_n = 1'b0; #1;
        check("reset_in_drain", outs(), v6(6'b000000));
        tick(); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            check("run_after_drain_reset", outs(), v6(6'b110000));
        end

`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_reset", stall_cycles, 32'd0);
        check("perf_flush_reset", flush_count, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); idle(); load_use_rs1(); #2;
            tick(); idle(); #2;
        end
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); mem_busy = 1'b1; ex_redirect = 1'b1; #2;
        end
        tick(); idle(); ex_redirect = 1'b1; #2;
        tick(); idle(); #2;
        check("perf_stall_cycles", stall_cycles, 32'd6);
        check("perf_flush_count", flush_count, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
